// File: rtl/if_prefetch_queue_if.sv
// Fetch front-end bus: memory request/response, decode-side output,
// redirect input and occupancy. master = fetch unit, slave = environment.
interface if_prefetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          inst_req_valid;
   logic          inst_req_ready;
   logic [31:0]   inst_addr;
   logic [31:0]   inst_resp_data;
   logic          inst_resp_valid;
   logic          inst_resp_ready;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_inst;
   logic [31:0]   out_pc;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] queue_count;

   modport master (
      output inst_req_valid, inst_addr, inst_resp_ready,
             out_valid, out_inst, out_pc, queue_count,
      input  inst_req_ready, inst_resp_data, inst_resp_valid,
             out_ready, redirect, redirect_pc
   );

   modport slave (
      input  inst_req_valid, inst_addr, inst_resp_ready,
             out_valid, out_inst, out_pc, queue_count,
      output inst_req_ready, inst_resp_data, inst_resp_valid,
             out_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches with bounded
// outstanding requests, buffers {pc, inst} in a FIFO, flushes on redirect
// and drops responses belonging to requests issued before the redirect.
module if_prefetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input logic                 clk,
   input logic                 rst,
   if_prefetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t        fifo [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [OW-1:0] inflight, inflight_nxt, discard;
   logic [31:0]   fpc, exp_pc, redir_pc, occupancy;
   logic          req_fire, resp_fire, push, pop;

   // Credit rule: count + inflight never exceeds DEPTH, so every
   // response is guaranteed a free FIFO slot when it lands.
   assign occupancy          = 32'(count) + 32'(inflight);
   assign bus.inst_req_valid = !rst && (32'(inflight) < 32'(MAX_OUTSTANDING))
                               && (occupancy < 32'(DEPTH));
   assign bus.inst_addr       = fpc;
   assign bus.inst_resp_ready = !rst;

   assign req_fire     = bus.inst_req_valid && bus.inst_req_ready;
   assign resp_fire    = bus.inst_resp_valid && bus.inst_resp_ready;
   assign inflight_nxt = inflight + OW'(req_fire) - OW'(resp_fire);
   assign redir_pc     = bus.redirect_pc & ~32'h3;

   // Stale responses (discard != 0) and any response in a redirect cycle are dropped.
   assign push = resp_fire && (discard == '0) && !bus.redirect;
   assign pop  = bus.out_valid && bus.out_ready && !bus.redirect;

   assign bus.out_valid   = !rst && (count != '0);
   assign bus.out_inst    = fifo[rd_ptr].inst;
   assign bus.out_pc      = fifo[rd_ptr].pc;
   assign bus.queue_count = rst ? '0 : count;

   // Control state: fetch/expected PCs, FIFO pointers, credit counters; redirect has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         fpc      <= RESET_PC;
         exp_pc   <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         discard  <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (bus.redirect) begin
            fpc     <= redir_pc;
            exp_pc  <= redir_pc;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            // Everything still outstanding after this cycle belongs to the old stream.
            discard <= inflight_nxt;
         end else begin
            if (req_fire) fpc <= fpc + 32'd4;
            if (resp_fire && (discard != '0)) discard <= discard - OW'(1);
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
               exp_pc <= exp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // FIFO storage: no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= '{pc: exp_pc, inst: bus.inst_resp_data};
   end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: in-order memory model with configurable
// latency, scoreboard of expected {pc, inst} built from accepted fetches,
// a redirect vector table and hand-written corner sequences.
module tb_if_prefetch_queue;
   localparam int          DEPTH = 4;
   localparam int          MAXO  = 2;
   localparam logic [31:0] RPC   = 32'h0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_prefetch_queue_if #(.DEPTH(DEPTH)) bus();

   if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void timeout(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting", name);
   endfunction

   function automatic logic [31:0] img(logic [31:0] a);
      return a ^ {a[15:0], 16'h0} ^ 32'hC0DE_0000;
   endfunction

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } sb_t;
   mreq_t       pend[$];
   sb_t         sb[$];
   int          lat = 1;
   int          cyc = 0;
   logic        req_fire_s   = 1'b0;
   logic        resp_taken_s = 1'b0;
   logic [31:0] addr_s       = '0;
   logic [31:0] m_fpc        = RPC;

   // Memory model: in-order, fixed latency, cleared by reset.
   always @(posedge clk) begin
      #2;
      cyc++;
      if (rst) pend.delete();
      else begin
         if (resp_taken_s && pend.size() > 0) void'(pend.pop_front());
         if (req_fire_s) pend.push_back('{addr_s, cyc + lat - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.inst_resp_valid = 1'b1;
         bus.inst_resp_data  = img(pend[0].addr);
      end else begin
         bus.inst_resp_valid = 1'b0;
         bus.inst_resp_data  = '0;
      end
   end

   // Monitor: samples what will happen at the next edge; scoreboard push/pop/flush.
   always @(negedge clk) begin
      sb_t e;
      req_fire_s   = bus.inst_req_valid && bus.inst_req_ready;
      resp_taken_s = bus.inst_resp_valid && bus.inst_resp_ready;
      addr_s       = bus.inst_addr;
      if (rst) begin
         sb.delete();
         m_fpc = RPC;
      end else begin
         if (bus.out_valid && bus.out_ready && !bus.redirect) begin
            if (sb.size() == 0) timeout("unexpected_out");
            else begin
               e = sb.pop_front();
               chk("out_pc", bus.out_pc, e.pc);
               chk("out_inst", bus.out_inst, e.inst);
            end
         end
         if (req_fire_s) begin
            chk("inst_addr", bus.inst_addr, m_fpc);
            chk("outstanding_le_max",
                32'((pend.size() - (resp_taken_s ? 1 : 0) + 1) <= MAXO), 32'd1);
            sb.push_back('{m_fpc, img(m_fpc)});
            m_fpc = m_fpc + 32'd4;
         end
         if (bus.redirect) begin
            sb.delete();
            m_fpc = {bus.redirect_pc[31:2], 2'b00};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(); rst = 1'b1; bus.redirect = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_queue_count", 32'(bus.queue_count), 0);
      chk("rst_req_valid", 32'(bus.inst_req_valid), 0);
      chk("rst_resp_ready", 32'(bus.inst_resp_ready), 0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("first_req_valid", 32'(bus.inst_req_valid), 1);
      chk("first_req_addr", bus.inst_addr, RPC);
   endtask

   task automatic wait_req(int bound, logic [31:0] exp, string name);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.inst_req_valid) begin
            chk(name, bus.inst_addr, exp);
            return;
         end
      end
      timeout(name);
   endtask

   task automatic wait_out(int bound, logic [31:0] exp, string name);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            chk(name, bus.out_pc, exp);
            return;
         end
      end
      timeout(name);
   endtask

   typedef struct { logic [31:0] rpc; logic [31:0] exp; } vec_t;

   initial begin
      vec_t vt[5];
      bit   found;
      vt[0] = '{32'h0000_0103, 32'h0000_0100};
      vt[1] = '{32'h0000_0200, 32'h0000_0200};
      vt[2] = '{32'h0000_0007, 32'h0000_0004};
      vt[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
      vt[4] = '{32'h1000_0001, 32'h1000_0000};

      rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0;
      bus.out_ready = 1'b1; bus.inst_req_ready = 1'b1;

      // 1: sequential stream, 1-cycle memory: out_valid two cycles after first request.
      lat = 1;
      do_reset();
      chk("lat_c0_out_valid", 32'(bus.out_valid), 0);
      @(negedge clk); chk("lat_c1_out_valid", 32'(bus.out_valid), 0);
      @(negedge clk); chk("lat_c2_out_valid", 32'(bus.out_valid), 1);
      chk("lat_c2_out_pc", bus.out_pc, RPC);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); chk("throughput_valid", 32'(bus.out_valid), 1);
      end

      // 2: decode stalled: credit rule stops fetching at 4, then drains in order.
      tick(); bus.out_ready = 1'b0;
      do_reset();
      repeat (12) @(negedge clk);
      chk("stall_queue_count", 32'(bus.queue_count), 4);
      chk("stall_req_valid", 32'(bus.inst_req_valid), 0);
      chk("stall_head_pc", bus.out_pc, 32'h0);
      tick(); bus.out_ready = 1'b1;
      wait_req(10, 32'h10, "resume_addr");
      repeat (10) @(negedge clk);

      // 3: redirect with 0x8 and 0xC outstanding on a 3-cycle memory.
      lat = 3;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = pend.size() == 2 && pend[0].addr == 32'h8 && pend[1].addr == 32'hC
                 && !bus.inst_resp_valid;
      end
      if (!found) timeout("two_inflight");
      tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
      tick(); bus.redirect = 1'b0;
      @(negedge clk);
      chk("redir_queue_count", 32'(bus.queue_count), 0);
      wait_out(20, 32'h100, "redir_first_out");
      repeat (10) @(negedge clk);

      // 4/5: redirects in steady state (handshake + response in the redirect cycle).
      lat = 1;
      do_reset();
      repeat (6) @(negedge clk);
      for (int v = 0; v < 5; v++) begin
         tick(); bus.redirect = 1'b1; bus.redirect_pc = vt[v].rpc;
         @(negedge clk);
         chk("redir_cycle_busy",
             32'({bus.inst_req_valid, bus.inst_req_ready, bus.inst_resp_valid}), 32'h7);
         tick(); bus.redirect = 1'b0;
         wait_req(5, vt[v].exp, "redir_req_addr");
         wait_out(10, vt[v].exp, "redir_out_pc");
         repeat (5) @(negedge clk);
      end
      tick(); bus.inst_req_ready = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_queue_count", 32'(bus.queue_count), 0);
      chk("idle_mem_pending", 32'(pend.size()), 0);
      chk("idle_req_valid", 32'(bus.inst_req_valid), 1);
      tick(); bus.inst_req_ready = 1'b1;
      repeat (6) @(negedge clk);

      // 6: 3-cycle memory with random back-pressure, then reset mid-stream.
      lat = 3;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         tick();
         bus.out_ready      = 1'($urandom_range(0, 1));
         bus.inst_req_ready = 1'($urandom_range(0, 1));
      end
      tick(); bus.out_ready = 1'b1; bus.inst_req_ready = 1'b1;
      repeat (6) @(negedge clk);
      tick(); rst = 1'b1;
      @(negedge clk); chk("midrst_out_valid_c0", 32'(bus.out_valid), 0);
      tick();
      @(negedge clk); chk("midrst_out_valid_c1", 32'(bus.out_valid), 0);
      chk("midrst_queue_count", 32'(bus.queue_count), 0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("restart_req_valid", 32'(bus.inst_req_valid), 1);
      chk("restart_addr", bus.inst_addr, RPC);
      wait_out(20, RPC, "restart_first_out");
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
